seq_datapath: RTL and testbench

//  Parametrised successor to the single-bus CPU datapath. Holds a register file, Y, Z_HI/Z_LO and HI/LO on one shared bus.
//  A built-in T-state sequencer replaces the hand-driven Rout/Rin/Yin/Zin strobes: a single start

---
 rtl/dp_pkg.sv | 33 +++
 rtl/dp_if.sv | 39 +++
 rtl/dp_alu.sv | 50 +++++
 rtl/seq_datapath.sv | 133 +++++++++++++
 tb/tb_seq_datapath.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared opcode and sequencer-state definitions for the sequenced single-bus datapath.
// Includes opcode classification helpers used by the FSM.
package dp_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_SHL = 5'd4;
    localparam logic [OP_W-1:0] OP_SHR = 5'd5;
    localparam logic [OP_W-1:0] OP_ROL = 5'd6;
    localparam logic [OP_W-1:0] OP_MUL = 5'd7;
    localparam logic [OP_W-1:0] OP_NEG = 5'd8;
    localparam logic [OP_W-1:0] OP_NOT = 5'd9;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TY   = 3'd1;
    localparam logic [2:0] S_TZ   = 3'd2;
    localparam logic [2:0] S_TWB  = 3'd3;
    localparam logic [2:0] S_TWB2 = 3'd4;
    localparam logic [2:0] S_TERR = 3'd5;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/dp_if.sv
// Control-unit to datapath interface: op issue, external load, debug read and status.
// The control unit uses the master modport; seq_datapath uses the slave modport.
interface dp_if
    import dp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int IW = $clog2(NREGS);

    logic             start;
    logic [OP_W-1:0]  op;
    logic [IW-1:0]    ra;
    logic [IW-1:0]    rb;
    logic [IW-1:0]    rc;
    logic             ld_en;
    logic [IW-1:0]    ld_idx;
    logic [WIDTH-1:0] ld_data;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             err;
    logic             ld_drop;

    modport master (
        output start, op, ra, rb, rc, ld_en, ld_idx, ld_data, rd_idx,
        input  rd_data, bus_out, hi, lo, busy, done, err, ld_drop
    );

    modport slave (
        input  start, op, ra, rb, rc, ld_en, ld_idx, ld_data, rd_idx,
        output rd_data, bus_out, hi, lo, busy, done, err, ld_drop
    );

endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: a is the Y operand, b is the bus operand (sole operand for unary ops).
// Returns a double-width result; only MUL produces a non-zero upper half.
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]          op,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    output logic [2*WIDTH-1:0]       res
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]            sh;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          rol_v;
    logic [WIDTH-1:0]          hi_d;
    logic [WIDTH-1:0]          lo_d;

    assign sh    = b[SHW-1:0];
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    // Low 2*WIDTH bits of the extended product equal the exact signed product.
    assign prod  = a_ext * b_ext;
    assign rol_v = WIDTH'(({a, a} << sh) >> WIDTH);

    always_comb begin
        hi_d = '0;
        lo_d = '0;
        case (op)
            OP_ADD:  lo_d = a + b;
            OP_SUB:  lo_d = a - b;
            OP_AND:  lo_d = a & b;
            OP_OR:   lo_d = a | b;
            OP_SHL:  lo_d = a << sh;
            OP_SHR:  lo_d = a >> sh;
            OP_ROL:  lo_d = rol_v;
            OP_MUL:  {hi_d, lo_d} = prod;
            OP_NEG:  lo_d = -b;
            OP_NOT:  lo_d = ~b;
            default: lo_d = '0;
        endcase
    end

    assign res = {hi_d, lo_d};

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath with register file, Y, Z, HI/LO and a T-state sequencer that runs
// one register-to-register ALU op per start and signals completion with a done pulse.
module seq_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic clk,
    input  logic clr,
    dp_if.slave  dp
);
    localparam int IW = $clog2(NREGS);

    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   zhi_q;
    logic [WIDTH-1:0]   zlo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [OP_W-1:0]    op_q;
    logic [IW-1:0]      ra_q;
    logic [IW-1:0]      rb_q;
    logic [IW-1:0]      rc_q;
    logic               done_q;
    logic               err_q;
    logic               ld_drop_q;
    logic               done_d;
    logic               accept;
    logic               ld_ok;
    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_res;

    function automatic logic [WIDTH-1:0] rf_read(input logic [IW-1:0] idx);
        if (R0_ZERO && (idx == '0)) return '0;
        return regs_q[idx];
    endfunction

    assign accept = (state_q == S_IDLE) && dp.start;
    assign ld_ok  = (state_q == S_IDLE) && dp.ld_en && !(R0_ZERO && (dp.ld_idx == '0));

    // One bus source per state; no source drives it in IDLE or T_ERR.
    always_comb begin
        bus = '0;
        case (state_q)
            S_TY:    bus = rf_read(rb_q);
            S_TZ:    bus = is_unary(op_q) ? rf_read(rb_q) : rf_read(rc_q);
            S_TWB:   bus = zlo_q;
            S_TWB2:  bus = zhi_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (dp.start) begin
                    if (!is_legal(dp.op))     state_d = S_TERR;
                    else if (is_unary(dp.op)) state_d = S_TZ;
                    else                      state_d = S_TY;
                end
            end
            S_TY:    state_d = S_TZ;
            S_TZ:    state_d = S_TWB;
            S_TWB:   state_d = (op_q == OP_MUL) ? S_TWB2 : S_IDLE;
            S_TWB2:  state_d = S_IDLE;
            S_TERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign done_d = (state_q != S_IDLE) && (state_d == S_IDLE);

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (op_q),
        .a   (y_q),
        .b   (bus),
        .res (alu_res)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            y_q       <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            state_q   <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ld_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            err_q     <= (state_q == S_TERR);
            ld_drop_q <= dp.ld_en && (state_q != S_IDLE);
            if (accept) begin
                op_q <= dp.op;
                ra_q <= dp.ra;
                rb_q <= dp.rb;
                rc_q <= dp.rc;
            end
            // A same-edge load lands before T_Y reads the file, so the op sees it.
            if (ld_ok) regs_q[dp.ld_idx] <= dp.ld_data;
            if (state_q == S_TY) y_q <= bus;
            if (state_q == S_TZ) {zhi_q, zlo_q} <= alu_res;
            if (state_q == S_TWB) begin
                if (op_q == OP_MUL)                 lo_q <= bus;
                else if (!(R0_ZERO && ra_q == '0))  regs_q[ra_q] <= bus;
            end
            if (state_q == S_TWB2) hi_q <= bus;
        end
    end

    assign dp.rd_data = rf_read(dp.rd_idx);
    assign dp.bus_out = bus;
    assign dp.hi      = hi_q;
    assign dp.lo      = lo_q;
    assign dp.busy    = (state_q != S_IDLE);
    assign dp.done    = done_q;
    assign dp.err     = err_q;
    assign dp.ld_drop = ld_drop_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed scenarios plus randomized ops against a behavioural model.
module tb_seq_datapath;
    localparam int W = 32;
    localparam int N = 16;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] exp_bus [$];
    int           exp_lat;
    bit           exp_err;
    logic [W-1:0] obs_bus [8];
    int           obs_n;
    int           start_cyc;

    dp_if #(.WIDTH(W), .NREGS(N)) dp ();
    dp_if #(.WIDTH(W), .NREGS(N)) dp2 ();

    seq_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b0)) u_dut (.clk(clk), .clr(clr), .dp(dp));
    seq_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b1)) u_dut_r0 (.clk(clk), .clr(clr), .dp(dp2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference ALU: x is the first source, y the second (the only one for unary ops).
    function automatic logic [2*W-1:0] ref_alu(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int sh;
        longint p;
        logic [W-1:0] h;
        logic [W-1:0] l;
        sh = int'(y % W);
        h = '0;
        l = '0;
        case (o)
            5'd0: l = x + y;
            5'd1: l = x - y;
            5'd2: l = x & y;
            5'd3: l = x | y;
            5'd4: l = x << sh;
            5'd5: l = x >> sh;
            5'd6: l = (sh == 0) ? x : ((x << sh) | (x >> (W - sh)));
            5'd7: begin
                p = longint'($signed(x)) * longint'($signed(y));
                h = p[63:32];
                l = p[31:0];
            end
            5'd8: l = '0 - y;
            5'd9: l = ~y;
            default: l = '0;
        endcase
        return {h, l};
    endfunction

    task automatic model_op(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [2*W-1:0] r;
        bit un;
        exp_bus.delete();
        if (o > 5'd9) begin
            exp_lat = 2;
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        un = (o == 5'd8) || (o == 5'd9);
        s1 = m_regs[b];
        s2 = un ? m_regs[b] : m_regs[c];
        r = ref_alu(o, s1, s2);
        if (!un) exp_bus.push_back(s1);
        exp_bus.push_back(s2);
        exp_bus.push_back(r[W-1:0]);
        if (o == 5'd7) begin
            exp_bus.push_back(r[2*W-1:W]);
            m_hi = r[2*W-1:W];
            m_lo = r[W-1:0];
            exp_lat = 5;
        end else begin
            m_regs[a] = r[W-1:0];
            exp_lat = un ? 3 : 4;
        end
    endtask

    task automatic do_load(input logic [3:0] i, input logic [W-1:0] d);
        dp.ld_en = 1'b1;
        dp.ld_idx = i;
        dp.ld_data = d;
        @(posedge clk);
        #1;
        dp.ld_en = 1'b0;
        m_regs[i] = d;
    endtask

    // Drives one op, then records bus values until done; lat counts edges from the start edge to the edge sampling done.
    task automatic issue_op(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input bit sync, input bit lden, input logic [3:0] li, input logic [W-1:0] ldd,
                            output int lat, output bit errf);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        dp.start = 1'b1;
        dp.op = o;
        dp.ra = a;
        dp.rb = b;
        dp.rc = c;
        dp.ld_en = lden;
        dp.ld_idx = li;
        dp.ld_data = ldd;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        dp.start = 1'b0;
        dp.ld_en = 1'b0;
        obs_n = 0;
        lat = -1;
        errf = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (dp.done) begin
                lat = k + 1;
                errf = dp.err;
                break;
            end
            if (obs_n < 8) begin
                obs_bus[obs_n] = dp.bus_out;
                obs_n++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_reg(input logic [3:0] i, output logic [W-1:0] v);
        dp.rd_idx = i;
        #1;
        v = dp.rd_data;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0;
        m_lo = '0;
        n_vec++; if (dp.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", dp.busy); end
        n_vec++; if (dp.done !== 1'b0 || dp.err !== 1'b0 || dp.ld_drop !== 1'b0) begin n_bad++; $display("FAIL reset_flags: done=%b err=%b ld_drop=%b want 000", dp.done, dp.err, dp.ld_drop); end
        n_vec++; if (dp.hi !== '0 || dp.lo !== '0) begin n_bad++; $display("FAIL reset_hilo: hi=%h lo=%h want 0", dp.hi, dp.lo); end
        n_vec++; if (dp.bus_out !== '0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", dp.bus_out); end
        for (int i = 0; i < N; i++) begin
            read_reg(4'(i), v);
            n_vec++; if (v !== '0) begin n_bad++; $display("FAIL reset_reg R%0d: got %h want 0", i, v); end
        end
    endtask

    task automatic test_add();
        int lat;
        bit errf;
        logic [W-1:0] v;
        do_load(4'd2, 32'd5);
        do_load(4'd4, 32'd7);
        model_op(5'd0, 4'd5, 4'd2, 4'd4);
        issue_op(5'd0, 4'd5, 4'd2, 4'd4, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL add_latency: got %0d want 4", lat); end
        n_vec++; if (errf !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", errf); end
        n_vec++; if (obs_n !== 3) begin n_bad++; $display("FAIL add_bus_len: got %0d want 3", obs_n); end
        n_vec++; if (obs_bus[0] !== 32'd5 || obs_bus[1] !== 32'd7 || obs_bus[2] !== 32'd12) begin
            n_bad++; $display("FAIL add_bus_seq: got %0d,%0d,%0d want 5,7,12", obs_bus[0], obs_bus[1], obs_bus[2]);
        end
        read_reg(4'd5, v);
        n_vec++; if (v !== 32'd12) begin n_bad++; $display("FAIL add_result R5: got %0d want 12", v); end
    endtask

    task automatic test_mul();
        int lat;
        bit errf;
        do_load(4'd1, 32'h0000FFFF);
        do_load(4'd2, 32'h00010000);
        model_op(5'd7, 4'd7, 4'd1, 4'd2);
        issue_op(5'd7, 4'd7, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL mul_latency: got %0d want 5", lat); end
        n_vec++; if (dp.hi !== 32'h00000000 || dp.lo !== 32'hFFFF0000) begin n_bad++; $display("FAIL mul_pos: hi=%h lo=%h want 00000000 ffff0000", dp.hi, dp.lo); end
        n_vec++; if (obs_n !== 4 || obs_bus[3] !== 32'h0) begin n_bad++; $display("FAIL mul_bus: n=%0d last=%h want 4 00000000", obs_n, obs_bus[3]); end
        do_load(4'd1, 32'hFFFFFFFD);
        do_load(4'd2, 32'd4);
        model_op(5'd7, 4'd7, 4'd1, 4'd2);
        issue_op(5'd7, 4'd7, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL mul_neg_latency: got %0d want 5", lat); end
        n_vec++; if (dp.hi !== 32'hFFFFFFFF || dp.lo !== 32'hFFFFFFF4) begin n_bad++; $display("FAIL mul_neg: hi=%h lo=%h want ffffffff fffffff4", dp.hi, dp.lo); end
    endtask

    task automatic test_shift_rot();
        int lat;
        bit errf;
        logic [W-1:0] v;
        do_load(4'd3, 32'h80000001);
        do_load(4'd6, 32'd1);
        model_op(5'd6, 4'd3, 4'd3, 4'd6);
        issue_op(5'd6, 4'd3, 4'd3, 4'd6, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        read_reg(4'd3, v);
        n_vec++; if (v !== 32'h00000003) begin n_bad++; $display("FAIL rol_result: got %h want 00000003", v); end
        do_load(4'd3, 32'h80000001);
        model_op(5'd5, 4'd3, 4'd3, 4'd6);
        issue_op(5'd5, 4'd3, 4'd3, 4'd6, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        read_reg(4'd3, v);
        n_vec++; if (v !== 32'h40000000) begin n_bad++; $display("FAIL shr_result: got %h want 40000000", v); end
        model_op(5'd9, 4'd8, 4'd3, 4'd0);
        issue_op(5'd9, 4'd8, 4'd3, 4'd0, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL not_latency: got %0d want 3", lat); end
        read_reg(4'd8, v);
        n_vec++; if (v !== 32'hBFFFFFFF) begin n_bad++; $display("FAIL not_result: got %h want bfffffff", v); end
    endtask

    task automatic test_illegal_busy();
        int lat;
        bit errf;
        logic [W-1:0] v;
        model_op(5'd15, 4'd1, 4'd2, 4'd3);
        issue_op(5'd15, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 4'd0, '0, lat, errf);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL illegal_latency: got %0d want 2", lat); end
        n_vec++; if (errf !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", errf); end
        for (int i = 0; i < N; i++) begin
            read_reg(4'(i), v);
            n_vec++; if (v !== m_regs[i]) begin n_bad++; $display("FAIL illegal_reg R%0d: got %h want %h", i, v, m_regs[i]); end
        end
        n_vec++; if (dp.hi !== m_hi || dp.lo !== m_lo) begin n_bad++; $display("FAIL illegal_hilo: hi=%h lo=%h want %h %h", dp.hi, dp.lo, m_hi, m_lo); end
        // ADD into R10; a second start and a load arrive while it is in T_Z.
        model_op(5'd0, 4'd10, 4'd2, 4'd4);
        @(posedge clk); #1;
        dp.start = 1'b1; dp.op = 5'd0; dp.ra = 4'd10; dp.rb = 4'd2; dp.rc = 4'd4;
        @(posedge clk); #1;
        dp.start = 1'b0;
        @(posedge clk); #1;
        dp.start = 1'b1; dp.op = 5'd1; dp.ra = 4'd11; dp.rb = 4'd2; dp.rc = 4'd4;
        dp.ld_en = 1'b1; dp.ld_idx = 4'd9; dp.ld_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        dp.start = 1'b0; dp.ld_en = 1'b0;
        n_vec++; if (dp.ld_drop !== 1'b1) begin n_bad++; $display("FAIL ld_drop_pulse: got %b want 1", dp.ld_drop); end
        @(posedge clk); #1;
        n_vec++; if (dp.done !== 1'b1 || dp.err !== 1'b0) begin n_bad++; $display("FAIL busy_done: done=%b err=%b want 1 0", dp.done, dp.err); end
        n_vec++; if (dp.ld_drop !== 1'b0) begin n_bad++; $display("FAIL ld_drop_width: got %b want 0", dp.ld_drop); end
        @(posedge clk); #1;
        n_vec++; if (dp.busy !== 1'b0) begin n_bad++; $display("FAIL second_start_ignored busy: got %b want 0", dp.busy); end
        for (int i = 0; i < N; i++) begin
            read_reg(4'(i), v);
            n_vec++; if (v !== m_regs[i]) begin n_bad++; $display("FAIL busy_reg R%0d: got %h want %h", i, v, m_regs[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        int s1;
        bit errf;
        logic [W-1:0] v;
        model_op(5'd0, 4'd12, 4'd2, 4'd4);
        issue_op(5'd0, 4'd12, 4'd2, 4'd4, 1'b1, 1'b0, 4'd0, '0, lat1, errf);
        s1 = start_cyc;
        model_op(5'd1, 4'd13, 4'd12, 4'd6);
        issue_op(5'd1, 4'd13, 4'd12, 4'd6, 1'b0, 1'b0, 4'd0, '0, lat2, errf);
        n_vec++; if (lat1 !== 4 || lat2 !== 4) begin n_bad++; $display("FAIL b2b_latency: got %0d,%0d want 4,4", lat1, lat2); end
        n_vec++; if (start_cyc - s1 !== 4) begin n_bad++; $display("FAIL b2b_gap: start spacing %0d want 4", start_cyc - s1); end
        read_reg(4'd13, v);
        n_vec++; if (v !== m_regs[13]) begin n_bad++; $display("FAIL b2b_chain R13: got %h want %h", v, m_regs[13]); end
    endtask

    task automatic test_clr();
        logic [W-1:0] v;
        @(posedge clk); #1;
        dp.start = 1'b1; dp.op = 5'd0; dp.ra = 4'd14; dp.rb = 4'd2; dp.rc = 4'd4;
        @(posedge clk); #1;
        dp.start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0;
        m_lo = '0;
        n_vec++; if (dp.busy !== 1'b0 || dp.done !== 1'b0) begin n_bad++; $display("FAIL clr_abort: busy=%b done=%b want 0 0", dp.busy, dp.done); end
        n_vec++; if (dp.hi !== '0 || dp.lo !== '0) begin n_bad++; $display("FAIL clr_hilo: hi=%h lo=%h want 0", dp.hi, dp.lo); end
        for (int i = 0; i < N; i++) begin
            read_reg(4'(i), v);
            n_vec++; if (v !== '0) begin n_bad++; $display("FAIL clr_reg R%0d: got %h want 0", i, v); end
        end
        @(posedge clk); #1;
        n_vec++; if (dp.done !== 1'b0) begin n_bad++; $display("FAIL clr_no_done: got %b want 0", dp.done); end
        // R0-as-zero instance.
        dp2.ld_en = 1'b1; dp2.ld_idx = 4'd0; dp2.ld_data = 32'd9;
        @(posedge clk); #1;
        dp2.ld_idx = 4'd1;
        @(posedge clk); #1;
        dp2.ld_en = 1'b0;
        dp2.rd_idx = 4'd0; #1;
        n_vec++; if (dp2.rd_data !== '0) begin n_bad++; $display("FAIL r0_load: got %h want 0", dp2.rd_data); end
        dp2.rd_idx = 4'd1; #1;
        n_vec++; if (dp2.rd_data !== 32'd9) begin n_bad++; $display("FAIL r0_r1_load: got %h want 9", dp2.rd_data); end
        dp2.start = 1'b1; dp2.op = 5'd0; dp2.ra = 4'd0; dp2.rb = 4'd1; dp2.rc = 4'd1;
        @(posedge clk); #1;
        dp2.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (dp2.done !== 1'b1) begin n_bad++; $display("FAIL r0_done: got %b want 1", dp2.done); end
        dp2.rd_idx = 4'd0; #1;
        n_vec++; if (dp2.rd_data !== '0) begin n_bad++; $display("FAIL r0_op_write: got %h want 0", dp2.rd_data); end
    endtask

    task automatic test_random();
        int lat;
        bit errf;
        logic [4:0] o;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] li;
        logic [W-1:0] ldd;
        bit lden;
        bit sync;
        logic [W-1:0] v;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) do_load(4'($urandom_range(0, N - 1)), $urandom);
            o = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
            a = 4'($urandom_range(0, N - 1));
            b = 4'($urandom_range(0, N - 1));
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, W - 1)) : 4'($urandom_range(0, N - 1));
            li = 4'($urandom_range(0, N - 1));
            ldd = $urandom;
            lden = ($urandom_range(0, 3) == 0);
            sync = (it == 0) || ($urandom_range(0, 1) == 1);
            if (lden) m_regs[li] = ldd;
            model_op(o, a, b, c);
            issue_op(o, a, b, c, sync, lden, li, ldd, lat, errf);
            n_vec++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rnd_latency it%0d op%0d: got %0d want %0d", it, o, lat, exp_lat); end
            n_vec++; if (errf !== exp_err) begin n_bad++; $display("FAIL rnd_err it%0d op%0d: got %b want %b", it, o, errf, exp_err); end
            if (!exp_err) begin
                n_vec++; if (obs_n !== exp_bus.size()) begin n_bad++; $display("FAIL rnd_bus_len it%0d: got %0d want %0d", it, obs_n, exp_bus.size()); end
                for (int k = 0; k < exp_bus.size() && k < obs_n; k++) begin
                    n_vec++; if (obs_bus[k] !== exp_bus[k]) begin n_bad++; $display("FAIL rnd_bus it%0d step%0d: got %h want %h", it, k, obs_bus[k], exp_bus[k]); end
                end
            end
            n_vec++; if (dp.hi !== m_hi || dp.lo !== m_lo) begin n_bad++; $display("FAIL rnd_hilo it%0d: hi=%h lo=%h want %h %h", it, dp.hi, dp.lo, m_hi, m_lo); end
            read_reg(a, v);
            n_vec++; if (v !== m_regs[a]) begin n_bad++; $display("FAIL rnd_dest it%0d R%0d: got %h want %h", it, a, v, m_regs[a]); end
        end
        for (int i = 0; i < N; i++) begin
            read_reg(4'(i), v);
            n_vec++; if (v !== m_regs[i]) begin n_bad++; $display("FAIL rnd_final R%0d: got %h want %h", i, v, m_regs[i]); end
        end
    endtask

    initial begin
        dp.start = 1'b0; dp.op = '0; dp.ra = '0; dp.rb = '0; dp.rc = '0;
        dp.ld_en = 1'b0; dp.ld_idx = '0; dp.ld_data = '0; dp.rd_idx = '0;
        dp2.start = 1'b0; dp2.op = '0; dp2.ra = '0; dp2.rb = '0; dp2.rc = '0;
        dp2.ld_en = 1'b0; dp2.ld_idx = '0; dp2.ld_data = '0; dp2.rd_idx = '0;
        test_reset();
        test_add();
        test_mul();
        test_shift_rot();
        test_illegal_busy();
        test_back_to_back();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
